// File: rtl/ysyx_25040111_csrfile_if.sv
// rtl/ysyx_25040111_csrfile_if.sv - writeback-to-CSR commit handshake bundle
interface ysyx_25040111_csrfile_if;
   logic        wr_valid;
   logic        wr_ready;
   logic [1:0]  wr_kind;
   logic [11:0] wr_addr;
   logic [31:0] wr_data;
   logic [31:0] wr_pc;

   modport master (
      output wr_valid, wr_kind, wr_addr, wr_data, wr_pc,
      input  wr_ready
   );

   modport slave (
      input  wr_valid, wr_kind, wr_addr, wr_data, wr_pc,
      output wr_ready
   );
endinterface

// File: rtl/ysyx_25040111_csrfile.sv
// rtl/ysyx_25040111_csrfile.sv - machine-mode CSR file with trap entry/return and cycle counter
// Optional counter: YSYX_25040111_MCYCLE_EN builds mcycle/mcycleh; without it they read 0.
module ysyx_25040111_csrfile (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [11:0]                   rd_addr1,
   input  logic [11:0]                   rd_addr2,
   output logic [31:0]                   rd_data1,
   output logic [31:0]                   rd_data2,
   ysyx_25040111_csrfile_if.slave        wr
);
   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;

   localparam logic [1:0] KIND_WRITE = 2'd0;
   localparam logic [1:0] KIND_ECALL = 2'd1;
   localparam logic [1:0] KIND_MRET  = 2'd2;

   localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

   typedef enum logic {S_IDLE, S_TRAP} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        ready;
   logic        fire;
   logic        do_write;
   logic        do_ecall;
   logic        do_mret;
   logic        mie;
   logic        mpie;
   logic [31:0] mtvec;
   logic [31:0] mepc;
   logic [31:0] mcause;
   logic [31:0] mstatus;
   logic [31:0] mcycle_rd;
   logic [31:0] mcycleh_rd;
   logic [1:0]  unused_pc_lsb;

   // MPP is hardwired to M-mode; only MIE/MPIE are real state
   assign mstatus       = {19'd0, 2'b11, 3'd0, mpie, 3'd0, mie, 3'd0};
   assign unused_pc_lsb = wr.wr_pc[1:0];
   assign wr.wr_ready   = ready;

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      fire      = 1'b0;
      case (state)
         S_IDLE: begin
            ready = 1'b1;
            fire  = wr.wr_valid;
            if (fire && (wr.wr_kind == KIND_ECALL)) begin
               state_nxt = S_TRAP;
            end
         end
         S_TRAP: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      do_write = fire && (wr.wr_kind == KIND_WRITE);
      do_ecall = fire && (wr.wr_kind == KIND_ECALL);
      do_mret  = fire && (wr.wr_kind == KIND_MRET);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         mie    <= 1'b0;
         mpie   <= 1'b0;
         mtvec  <= 32'd0;
         mepc   <= 32'd0;
         mcause <= 32'd0;
      end else begin
         state <= state_nxt;
         if (do_write) begin
            case (wr.wr_addr)
               CSR_MSTATUS: begin
                  mie  <= wr.wr_data[3];
                  mpie <= wr.wr_data[7];
               end
               CSR_MTVEC:  mtvec  <= {wr.wr_data[31:2], 2'b00};
               CSR_MEPC:   mepc   <= {wr.wr_data[31:2], 2'b00};
               CSR_MCAUSE: mcause <= wr.wr_data;
               default: ;
            endcase
         end
         if (do_ecall) begin
            mepc <= {wr.wr_pc[31:2], 2'b00};
         end
         if (do_mret) begin
            mie  <= mpie;
            mpie <= 1'b1;
         end
         // second half of trap entry; no commit can be accepted in this state
         if (state == S_TRAP) begin
            mcause <= CAUSE_ECALL_M;
            mpie   <= mie;
            mie    <= 1'b0;
         end
      end
   end

`ifdef YSYX_25040111_MCYCLE_EN
   logic [31:0] mcycle;
   logic [31:0] mcycleh;
   logic [63:0] cycle_inc;

   assign cycle_inc = {mcycleh, mcycle} + 64'd1;

   // a software write to either half freezes the whole counter for that edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcycle  <= 32'd0;
         mcycleh <= 32'd0;
      end else if (do_write && (wr.wr_addr == CSR_MCYCLE)) begin
         mcycle <= wr.wr_data;
      end else if (do_write && (wr.wr_addr == CSR_MCYCLEH)) begin
         mcycleh <= wr.wr_data;
      end else begin
         {mcycleh, mcycle} <= cycle_inc;
      end
   end

   assign mcycle_rd  = mcycle;
   assign mcycleh_rd = mcycleh;
`else
   assign mcycle_rd  = 32'd0;
   assign mcycleh_rd = 32'd0;
`endif

   function automatic logic [31:0] csr_read(input logic [11:0] addr);
      case (addr)
         CSR_MSTATUS:   csr_read = mstatus;
         CSR_MTVEC:     csr_read = mtvec;
         CSR_MEPC:      csr_read = mepc;
         CSR_MCAUSE:    csr_read = mcause;
         CSR_MCYCLE:    csr_read = mcycle_rd;
         CSR_MCYCLEH:   csr_read = mcycleh_rd;
         CSR_MVENDORID: csr_read = 32'h79737978;
         CSR_MARCHID:   csr_read = 32'h017E14EF;
         default:       csr_read = 32'd0;
      endcase
   endfunction

   always_comb begin
      rd_data1 = csr_read(rd_addr1);
      rd_data2 = csr_read(rd_addr2);
   end
endmodule

// File: tb/tb_ysyx_25040111_csrfile.sv
// tb/tb_ysyx_25040111_csrfile.sv - scoreboard bench for the CSR file
module tb_ysyx_25040111_csrfile;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] rd_addr1 = 12'd0;
   logic [11:0] rd_addr2 = 12'd0;
   logic [31:0] rd_data1;
   logic [31:0] rd_data2;
   int          total = 0;
   int          bad = 0;
   int          waited;

   typedef struct {
      string       tag;
      logic [11:0] addr;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];

   ysyx_25040111_csrfile_if cbus();

   ysyx_25040111_csrfile dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_addr1 (rd_addr1),
      .rd_addr2 (rd_addr2),
      .rd_data1 (rd_data1),
      .rd_data2 (rd_data2),
      .wr       (cbus.slave)
   );

   always #50 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic expect_csr(input string tag, input logic [11:0] addr, input logic [31:0] val);
      exp_t e;
      e.tag  = tag;
      e.addr = addr;
      e.val  = val;
      sb.push_back(e);
   endtask

   // called right after a falling edge; each entry costs 2 time units
   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         rd_addr1 = e.addr;
         rd_addr2 = 12'h7C0;
         #1;
         check({e.tag, "/p1"}, rd_data1, e.val);
         check({e.tag, "/p2_other"}, rd_data2, 32'd0);
         rd_addr1 = 12'h7C0;
         rd_addr2 = e.addr;
         #1;
         check({e.tag, "/p2"}, rd_data2, e.val);
      end
   endtask

   task automatic commit(input logic [1:0] kind, input logic [11:0] addr, input logic [31:0] data,
                         input logic [31:0] pc, output int stalls);
      stalls        = 0;
      cbus.wr_valid = 1'b1;
      cbus.wr_kind  = kind;
      cbus.wr_addr  = addr;
      cbus.wr_data  = data;
      cbus.wr_pc    = pc;
      while (cbus.wr_ready !== 1'b1 && stalls < 4) begin
         @(negedge clk);
         stalls++;
      end
      if (cbus.wr_ready !== 1'b1) check("commit_timeout", {31'd0, cbus.wr_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      cbus.wr_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cbus.wr_valid = 1'b0;
      cbus.wr_kind  = 2'd3;
      cbus.wr_addr  = 12'd0;
      cbus.wr_data  = 32'd0;
      cbus.wr_pc    = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      check("rst_ready", {31'd0, cbus.wr_ready}, 32'd1);
      expect_csr("rst_mstatus", 12'h300, 32'h0000_1800);
      expect_csr("rst_mvendorid", 12'hF11, 32'h7973_7978);
      expect_csr("rst_marchid", 12'hF12, 32'h017E_14EF);
      expect_csr("rst_unimpl", 12'h123, 32'd0);
      expect_csr("rst_mtvec", 12'h305, 32'd0);
      expect_csr("rst_mepc", 12'h341, 32'd0);
      expect_csr("rst_mcause", 12'h342, 32'd0);
      expect_csr("rst_mcycle", 12'hB00, 32'd0);
      expect_csr("rst_mcycleh", 12'hB80, 32'd0);
      drain();
      rst_n = 1'b1;

      cbus.wr_valid = 1'b1;
      cbus.wr_kind  = 2'd0;
      cbus.wr_addr  = 12'h305;
      cbus.wr_data  = 32'h8000_0103;
      rd_addr1      = 12'h305;
      #1;
      check("mtvec_commit_cycle", rd_data1, 32'd0);
      @(posedge clk);
      @(negedge clk);
      cbus.wr_valid = 1'b0;
      expect_csr("mtvec_wr", 12'h305, 32'h8000_0100);
      drain();

      commit(2'd0, 12'h341, 32'h1234_5677, 32'd0, waited);
      check("b2b_stall_mepc", waited, 32'd0);
      commit(2'd0, 12'h342, 32'hDEAD_BEEF, 32'd0, waited);
      check("b2b_stall_mcause", waited, 32'd0);
      commit(2'd0, 12'hF11, 32'd0, 32'd0, waited);
      commit(2'd0, 12'h123, 32'hFFFF_FFFF, 32'd0, waited);
      commit(2'd0, 12'h300, 32'hFFFF_FFFF, 32'd0, waited);
      expect_csr("mepc_wr", 12'h341, 32'h1234_5674);
      expect_csr("mcause_wr", 12'h342, 32'hDEAD_BEEF);
      expect_csr("ro_ignored", 12'hF11, 32'h7973_7978);
      expect_csr("unimpl_ignored", 12'h123, 32'd0);
      expect_csr("mstatus_mask", 12'h300, 32'h0000_1888);
      drain();

      commit(2'd0, 12'h300, 32'h0000_0008, 32'd0, waited);
      expect_csr("mstatus_mie", 12'h300, 32'h0000_1808);
      drain();

      cbus.wr_valid = 1'b1;
      cbus.wr_kind  = 2'd1;
      cbus.wr_pc    = 32'h8000_0046;
      check("ecall_ready_in", {31'd0, cbus.wr_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      cbus.wr_valid = 1'b0;
      check("ecall_busy", {31'd0, cbus.wr_ready}, 32'd0);
      expect_csr("ecall_mepc", 12'h341, 32'h8000_0044);
      expect_csr("ecall_mcause_old", 12'h342, 32'hDEAD_BEEF);
      expect_csr("ecall_mstatus_old", 12'h300, 32'h0000_1808);
      drain();
      @(negedge clk);
      check("ecall_ready_back", {31'd0, cbus.wr_ready}, 32'd1);
      expect_csr("ecall_mcause", 12'h342, 32'd11);
      expect_csr("ecall_mstatus", 12'h300, 32'h0000_1880);
      drain();

      commit(2'd2, 12'd0, 32'd0, 32'd0, waited);
      check("mret_stall", waited, 32'd0);
      expect_csr("mret_mstatus", 12'h300, 32'h0000_1888);
      drain();

      commit(2'd3, 12'h300, 32'd0, 32'h0000_0FFC, waited);
      expect_csr("noop_mstatus", 12'h300, 32'h0000_1888);
      expect_csr("noop_mepc", 12'h341, 32'h8000_0044);
      expect_csr("noop_mcause", 12'h342, 32'd11);
      expect_csr("noop_mtvec", 12'h305, 32'h8000_0100);
      drain();

      commit(2'd1, 12'd0, 32'd0, 32'h0000_1003, waited);
      commit(2'd0, 12'h342, 32'h0000_0055, 32'd0, waited);
      check("held_commit_stall", waited, 32'd1);
      expect_csr("held_mcause", 12'h342, 32'h0000_0055);
      expect_csr("held_mepc", 12'h341, 32'h0000_1000);
      expect_csr("held_mstatus", 12'h300, 32'h0000_1880);
      drain();

      commit(2'd0, 12'h300, 32'h0000_0008, 32'd0, waited);
      commit(2'd1, 12'd0, 32'd0, 32'h2000_0010, waited);
      rst_n         = 1'b0;
      cbus.wr_valid = 1'b1;
      cbus.wr_kind  = 2'd0;
      cbus.wr_addr  = 12'h305;
      cbus.wr_data  = 32'hFFFF_FFFC;
      @(posedge clk);
      @(negedge clk);
      rst_n         = 1'b1;
      cbus.wr_valid = 1'b0;
      check("trap_rst_ready", {31'd0, cbus.wr_ready}, 32'd1);
      expect_csr("trap_rst_mcause", 12'h342, 32'd0);
      expect_csr("trap_rst_mepc", 12'h341, 32'd0);
      expect_csr("trap_rst_mstatus", 12'h300, 32'h0000_1800);
      expect_csr("rst_edge_no_commit", 12'h305, 32'd0);
      drain();

`ifdef YSYX_25040111_MCYCLE_EN
      commit(2'd0, 12'hB00, 32'hFFFF_FFFE, 32'd0, waited);
      commit(2'd0, 12'hB80, 32'h0000_0005, 32'd0, waited);
      expect_csr("cyc_lo_wr", 12'hB00, 32'hFFFF_FFFE);
      expect_csr("cyc_hi_wr", 12'hB80, 32'h0000_0005);
      drain();
      @(negedge clk);
      expect_csr("cyc_lo_inc", 12'hB00, 32'hFFFF_FFFF);
      expect_csr("cyc_hi_hold", 12'hB80, 32'h0000_0005);
      drain();
      @(negedge clk);
      expect_csr("cyc_lo_wrap", 12'hB00, 32'd0);
      expect_csr("cyc_hi_carry", 12'hB80, 32'h0000_0006);
      drain();
`else
      commit(2'd0, 12'hB00, 32'h0000_1234, 32'd0, waited);
      commit(2'd0, 12'hB80, 32'h0000_0005, 32'd0, waited);
      expect_csr("nocyc_lo", 12'hB00, 32'd0);
      expect_csr("nocyc_hi", 12'hB80, 32'd0);
      drain();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
